sub16_serial: RTL and testbench
===============================

# sub16_serial

Multi-cycle 16-bit subtractor computing D = A − B − b_in one nibble per clock on a single 4-bit adder slice, with a borrow carried between cycles. It is the subtracting counterpart of the team's combinational 16-bit ripple adder. It targets area-constrained datapaths where a 5-cycle result is acceptable. Operands enter through a start/busy handshake, and the result is held until the next accepted start.

## Interface
- No parameters. Width is fixed at 16 bits as 4 nibbles.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request. Sampled only when `busy` = 0.
- `A`  input  16  minuend. Captured on the accepting edge.
- `B`  input  16  subtrahend. Captured on the accepting edge.
- `b_in`  input  1  borrow-in. Captured on the accepting edge.
- `busy`  output  1  high while a subtraction is in progress.
- `done`  output  1  one-cycle pulse; result valid.
- `D`  output  16  difference, held after `done`.
- `borrow_out`  output  1  unsigned borrow (1 when A < B + b_in).
- `overflow`  output  1  two's-complement signed overflow.

## Operation
- States and transitions:
  - IDLE: `start` → RUN, with cnt = 0.
  - RUN: cnt increments each edge. The edge with cnt = 3 → DONE.
  - DONE: `start` → RUN; otherwise → IDLE.
- Accept: on an edge with `start` = 1 and state ∈ {IDLE, DONE}.
  - A, B and b_in are copied into internal registers. Later input changes have no effect.
  - The borrow register is loaded with `b_in`.
- Each RUN edge, using nibble index cnt:
  - Slice inputs: A[4cnt+3:4cnt], ~B[4cnt+3:4cnt], carry-in = ~borrow.
  - The slice sum is written to D[4cnt+3:4cnt], and borrow ← ~carry-out.
  - Nibbles are processed LSB first.
- Arithmetic is modulo 2^16.
  - On the final RUN edge: `borrow_out` ← ~carry-out of nibble 3.
  - Also on that edge: `overflow` ← (A[15] ≠ B[15]) & (D[15] ≠ A[15]), using the captured A and B and the new D[15].
- D bits belonging to nibbles not yet written keep their previous values while RUN is in progress.
- `start` while `busy` = 1 is ignored, not queued.
- Reset at any time, including mid-RUN, forces state IDLE, cnt = 0 and all outputs to their reset values. The aborted operation produces no `done`.
- Reset values: `busy` 0, `done` 0, `D` 0x0000, `borrow_out` 0, `overflow` 0, internal borrow 0.

## Timing
- Accepting edge T0. Nibbles are written on edges T1–T4.
- `busy` = 1 from after T0 through after T3, and drops after T4.
- `done` = 1 for exactly the cycle following T4. `D`, `borrow_out` and `overflow` are valid in that cycle.
- Latency is 4 edges from accept to `done`.
- Back-to-back: a `start` during the `done` cycle is accepted at T5, giving one result per 5 cycles.
- All outputs are registered. No combinational path from inputs to outputs.
- `busy` = ~(state ∈ {IDLE, DONE}).

## Structure
- Package `sub16_pkg`:
  - state enum {IDLE, RUN, DONE};
  - NIBBLES = 4;
  - NIB_W = 4;
  - CNT_W = 2.
- One sub-module: `adder_4bit`, the existing 4-bit ripple adder, instantiated once. B inversion and the carry-in/borrow polarity conversion happen in `sub16_serial`.
- Operand nibble selection is a 4:1 mux indexed by cnt. The D nibble write is decoded from cnt.

## Test plan
- Basic subtract: A = 0x1234, B = 0x0234, b_in = 0.
  - Expect D = 0x1000, borrow_out = 0, overflow = 0.
  - `done` occurs exactly 4 edges after the accept, and `busy` is high for 4 cycles.
- Unsigned underflow: A = 0x0000, B = 0x0001.
  - Expect D = 0xFFFF, borrow_out = 1, overflow = 0.
  - Borrow ripples through all 4 nibbles.
- Signed overflow: A = 0x8000, B = 0x0001.
  - Expect D = 0x7FFF, borrow_out = 0, overflow = 1.
- Signed overflow, other direction: A = 0x7FFF, B = 0xFFFF.
  - Expect D = 0x8000, borrow_out = 1, overflow = 1.
- Borrow-in: A = 0x0005, B = 0x0005, b_in = 1.
  - Expect D = 0xFFFF, borrow_out = 1.
- Handshake and reset:
  - `start` with A = 0x00FF, B = 0x0001 while busy; operands then change to 0xAAAA. Expect no effect, and a result of 0x00FE.
  - `start` held high during the `done` cycle: expect the next operation accepted at T5.
  - `rst_n` pulsed low after T2: expect all outputs 0 asynchronously, no `done`, and IDLE after release.

Source files
------------

// File: rtl/sub16_pkg.sv
// Shared types and sizing for the nibble-serial 16-bit subtractor.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sub16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLES = 4;
    localparam int NIB_W   = 4;
    localparam int CNT_W   = 2;
    localparam int DATA_W  = NIBBLES * NIB_W;

endpackage

// File: rtl/sub16_serial_if.sv
// Operand/result bundle for sub16_serial; master drives operands, slave returns the result.
// Latency: n/a (wiring only).
// Backpressure: start is only honoured while busy is low; nothing is queued.
interface sub16_serial_if;
    import sub16_pkg::*;

    logic              start;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              b_in;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] D;
    logic              borrow_out;
    logic              overflow;

    modport master (
        output start, A, B, b_in,
        input  busy, done, D, borrow_out, overflow
    );

    modport slave (
        input  start, A, B, b_in,
        output busy, done, D, borrow_out, overflow
    );

endinterface

// File: rtl/adder_4bit.sv
// 4-bit ripple-carry adder slice, purely combinational.
// Latency: 0 cycles.
// Backpressure: none.
module adder_4bit
    import sub16_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < NIB_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/sub16_serial.sv
// D = A - B - b_in, one nibble per clock through a single adder_4bit slice.
// Latency: done pulses 4 edges after the accepting edge; one result per 5 cycles back-to-back.
// Backpressure: start is ignored (not queued) while busy is high.
module sub16_serial
    import sub16_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    sub16_serial_if.slave bus
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  d_q;
    logic               brw;
    logic               busy_q;
    logic               done_q;
    logic               bo_q;
    logic               ov_q;

    logic [NIB_W-1:0]   a_nib;
    logic [NIB_W-1:0]   b_nib;
    logic [NIB_W-1:0]   sum;
    logic               cout;
    logic               last_nib;

    // Operand nibble select, LSB nibble first.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        case (cnt)
            2'd0: begin a_nib = a_q[3:0];   b_nib = b_q[3:0];   end
            2'd1: begin a_nib = a_q[7:4];   b_nib = b_q[7:4];   end
            2'd2: begin a_nib = a_q[11:8];  b_nib = b_q[11:8];  end
            2'd3: begin a_nib = a_q[15:12]; b_nib = b_q[15:12]; end
            default: begin a_nib = '0; b_nib = '0; end
        endcase
    end

    // Subtraction as A + ~B + ~borrow; carry-out low means a borrow was taken.
    adder_4bit u_adder (
        .a    (a_nib),
        .b    (~b_nib),
        .cin  (~brw),
        .sum  (sum),
        .cout (cout)
    );

    assign last_nib = (cnt == CNT_W'(NIBBLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            brw    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bo_q   <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q    <= bus.A;
                        b_q    <= bus.B;
                        brw    <= bus.b_in;
                        cnt    <= '0;
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (cnt == CNT_W'(i)) begin
                            d_q[i*NIB_W +: NIB_W] <= sum;
                        end
                    end
                    brw <= ~cout;
                    cnt <= cnt + 1'b1;
                    if (last_nib) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        bo_q   <= ~cout;
                        ov_q   <= (a_q[DATA_W-1] ^ b_q[DATA_W-1]) & (sum[NIB_W-1] ^ a_q[DATA_W-1]);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.D          = d_q;
    assign bus.borrow_out = bo_q;
    assign bus.overflow   = ov_q;

endmodule

// File: tb/tb_sub16_serial.sv
// Scoreboard bench for sub16_serial: expected results queued at issue, popped on done.
module tb_sub16_serial;

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bi;
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    sub16_serial_if bus();

    sub16_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bi);
        logic [16:0] r;
        exp_t        e;
        r    = {1'b0, a} - {1'b0, b} - {16'd0, bi};
        e.d  = r[15:0];
        e.bo = r[16];
        e.ov = (a[15] ^ b[15]) & (r[15] ^ a[15]);
        return e;
    endfunction

    // Issues one request and waits for done; lat = negedges to done (-1 on timeout).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                          input bit sync, output int lat, output int busy_cyc);
        lat      = -1;
        busy_cyc = 0;
        if (sync) @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.b_in  = bi;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.A     = 16'h5A5A;
                bus.B     = 16'hA5A5;
                bus.b_in  = 1'b1;
            end
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.b_in  = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.D !== 16'h0000) begin errors++; $display("FAIL reset_D: got %h expected 0000", bus.D); end
        checks++; if (bus.borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b expected 0", bus.borrow_out); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.overflow); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int   lat, bc;
        exp_t e;
        sb.push_back('{d: 16'h1000, bo: 1'b0, ov: 1'b0});
        run_op(16'h1234, 16'h0234, 1'b0, 1'b1, lat, bc);
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", lat); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 4", bc); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL basic_sb: got empty expected entry"); end
        else begin
            e = sb.pop_front();
            if (bus.D !== e.d || bus.borrow_out !== e.bo || bus.overflow !== e.ov) begin
                errors++;
                $display("FAIL basic_result: got %h/%b/%b expected %h/%b/%b", bus.D, bus.borrow_out, bus.overflow, e.d, e.bo, e.ov);
            end
        end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", bus.done); end
        checks++; if (bus.D !== 16'h1000) begin errors++; $display("FAIL basic_hold: got %h expected 1000", bus.D); end
    endtask

    task automatic test_arith();
        vec_t v[$];
        int   lat, bc;
        exp_t e;
        v.push_back('{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0});
        v.push_back('{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1});
        v.push_back('{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1});
        v.push_back('{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0});
        for (int i = 0; i < 8; i++) begin
            vec_t r;
            r.a  = 16'($urandom);
            r.b  = 16'($urandom);
            r.bi = 1'($urandom_range(0, 1));
            e    = model(r.a, r.b, r.bi);
            r.d  = e.d;
            r.bo = e.bo;
            r.ov = e.ov;
            v.push_back(r);
        end
        foreach (v[i]) begin
            sb.push_back('{d: v[i].d, bo: v[i].bo, ov: v[i].ov});
            run_op(v[i].a, v[i].b, v[i].bi, 1'b1, lat, bc);
            checks++;
            if (lat !== 5 || sb.size() == 0) begin
                errors++;
                $display("FAIL arith_latency[%0d]: got %0d expected 5", i, lat);
            end else begin
                e = sb.pop_front();
                if (bus.D !== e.d || bus.borrow_out !== e.bo || bus.overflow !== e.ov) begin
                    errors++;
                    $display("FAIL arith_result[%0d] %h-%h-%b: got %h/%b/%b expected %h/%b/%b", i, v[i].a, v[i].b,
                             v[i].bi, bus.D, bus.borrow_out, bus.overflow, e.d, e.bo, e.ov);
                end
            end
        end
        sb.delete();
    endtask

    task automatic test_busy_ignore();
        int   lat = -1;
        exp_t e;
        sb.push_back('{d: 16'h00FE, bo: 1'b0, ov: 1'b0});
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'h00FF;
        bus.B     = 16'h0001;
        bus.b_in  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.A    = 16'hAAAA;
                bus.B    = 16'hAAAA;
                bus.b_in = 1'b1;
            end
            if (k == 4) bus.start = 1'b0;
            if (bus.done === 1'b1) begin lat = k; break; end
        end
        checks++; if (lat !== 5) begin errors++; $display("FAIL busy_ignore_latency: got %0d expected 5", lat); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL busy_ignore_sb: got empty expected entry"); end
        else begin
            e = sb.pop_front();
            if (bus.D !== e.d) begin errors++; $display("FAIL busy_ignore_result: got %h expected %h", bus.D, e.d); end
        end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_idle: got %b expected 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int   lat, bc;
        exp_t e;
        sb.push_back('{d: 16'h0FF0, bo: 1'b0, ov: 1'b0});
        run_op(16'h1000, 16'h0010, 1'b0, 1'b1, lat, bc);
        checks++;
        if (lat !== 5 || sb.size() == 0) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 5", lat); end
        else begin
            e = sb.pop_front();
            if (bus.D !== e.d) begin errors++; $display("FAIL b2b_first_result: got %h expected %h", bus.D, e.d); end
        end
        sb.push_back('{d: 16'hFFF0, bo: 1'b1, ov: 1'b0});
        run_op(16'h0010, 16'h0020, 1'b0, 1'b0, lat, bc);
        checks++; if (bc !== 4) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected 4", bc); end
        checks++;
        if (lat !== 5 || sb.size() == 0) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 5", lat); end
        else begin
            e = sb.pop_front();
            if (bus.D !== e.d || bus.borrow_out !== e.bo || bus.overflow !== e.ov) begin
                errors++;
                $display("FAIL b2b_second_result: got %h/%b/%b expected %h/%b/%b", bus.D, bus.borrow_out, bus.overflow, e.d, e.bo, e.ov);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int   lat, bc;
        int   bad = 0;
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'h8000;
        bus.B     = 16'h0001;
        bus.b_in  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.D !== 16'h0000 ||
            bus.borrow_out !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: got %b/%b/%h/%b/%b expected 0/0/0000/0/0",
                     bus.busy, bus.done, bus.D, bus.borrow_out, bus.overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL midrun_no_done: got %0d bad cycles expected 0", bad); end
        sb.push_back('{d: 16'h0001, bo: 1'b0, ov: 1'b0});
        run_op(16'h0003, 16'h0002, 1'b0, 1'b1, lat, bc);
        checks++;
        if (lat !== 5 || sb.size() == 0) begin errors++; $display("FAIL midrun_after_latency: got %0d expected 5", lat); end
        else begin
            e = sb.pop_front();
            if (bus.D !== e.d) begin errors++; $display("FAIL midrun_after_result: got %h expected %h", bus.D, e.d); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
